// File: rtl/com_pkg.sv
// Shared types and constants for the com send arbiter.
// State encodings, packet types, default timeout, rr rank helper.
package com_pkg;

  typedef enum logic [7:0] {
    MAIN_IDLE = 8'h00,
    MAIN_WAIT = 8'h01,
    ARB_PICK  = 8'h10,
    SEND_DATA = 8'h21,
    SEND_DONE = 8'h22,
    SEND_ERR  = 8'h23,
    SRC_DONE  = 8'h30
  } com_state_e;

  localparam logic [15:0] COM_TIMEOUT_DEF = 16'h1000;

  localparam logic [3:0] BAG_NULL = 4'h0;
  localparam logic [3:0] BAG_CMD  = 4'h1;
  localparam logic [3:0] BAG_DATA = 4'h2;
  localparam logic [3:0] BAG_ACK  = 4'h3;
  localparam logic [3:0] BAG_NAK  = 4'h4;
  localparam logic [3:0] BAG_STAT = 4'hD;

  // Distance of index i after last in a ring of n requesters.
  // Rank 0 is last+1, the highest round-robin priority.
  function automatic logic [2:0] rr_rank(
    input logic [1:0] i,
    input logic [1:0] last,
    input logic [2:0] n
  );
    int t;
    t = int'(i) + 2 * int'(n) - int'(last) - 1;
    return 3'(t % int'(n));
  endfunction

endpackage

// File: rtl/com_rr_pick.sv
// Combinational round-robin pick over N send requesters.
// Ports: req (request vector), last_idx in; valid, idx out.
module com_rr_pick
  import com_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0] req,
  input  logic [1:0]   last_idx,
  output logic         valid,
  output logic [1:0]   idx
);

  logic [2:0] best;
  logic [2:0] rank;

  always_comb begin
    valid = 1'b0;
    idx   = 2'd0;
    best  = 3'd4;
    rank  = 3'd0;
    for (int i = 0; i < N; i++) begin
      rank = rr_rank(2'(i), last_idx, 3'(N));
      if (req[i] && rank < best) begin
        best  = rank;
        idx   = 2'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/com_arb.sv
// Round-robin send arbiter between requesters and link controller.
// Ports: clk, rst_n; src_fs/fd + src_* fields; fs/fd_send, send_*, status.
module com_arb
  import com_pkg::*;
#(
  parameter int          NUM_SRC = 3,
  parameter logic [15:0] TIMEOUT = COM_TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_SRC-1:0]    src_fs,
  output logic [NUM_SRC-1:0]    src_fd,
  input  logic [4*NUM_SRC-1:0]  src_btype,
  input  logic [12*NUM_SRC-1:0] src_dlen,
  input  logic [12*NUM_SRC-1:0] src_addr,
  output logic                  fs_send,
  input  logic                  fd_send,
  output logic [3:0]            send_btype,
  output logic [11:0]           send_dlen,
  output logic [11:0]           ram_addr_init,
  output logic [1:0]            grant_idx,
  output logic                  busy,
  output logic                  timeout_err
);

  com_state_e   state;
  logic [1:0]   last_idx;
  logic [15:0]  time_cnt;

  logic         pick_vld;
  logic [1:0]   pick_idx;
  logic [3:0]   pick_bt;
  logic [11:0]  pick_dl;
  logic [11:0]  pick_ad;
  logic         fs_gnt;
  logic [NUM_SRC-1:0] gnt_mask;

  com_rr_pick #(.N(NUM_SRC)) u_pick (
    .req      (src_fs),
    .last_idx (last_idx),
    .valid    (pick_vld),
    .idx      (pick_idx)
  );

  // Field mux for the winner, and strobe/mask of the held grant.
  always_comb begin
    pick_bt  = '0;
    pick_dl  = '0;
    pick_ad  = '0;
    fs_gnt   = 1'b0;
    gnt_mask = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (pick_idx == 2'(i)) begin
        pick_bt = src_btype[4*i +: 4];
        pick_dl = src_dlen[12*i +: 12];
        pick_ad = src_addr[12*i +: 12];
      end
      if (grant_idx == 2'(i)) begin
        fs_gnt      = src_fs[i];
        gnt_mask[i] = 1'b1;
      end
    end
  end

  // Outputs are registered: each is set on entry to the
  // state that owns it and cleared on exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= MAIN_IDLE;
      last_idx      <= 2'(NUM_SRC - 1);
      grant_idx     <= 2'd0;
      time_cnt      <= 16'd0;
      send_btype    <= 4'b0000;
      send_dlen     <= 12'h000;
      ram_addr_init <= 12'h000;
      fs_send       <= 1'b0;
      src_fd        <= '0;
      busy          <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      case (state)
        MAIN_IDLE: begin
          time_cnt <= 16'd0;
          busy     <= 1'b0;
          state    <= MAIN_WAIT;
        end
        MAIN_WAIT: begin
          time_cnt <= 16'd0;
          if (|src_fs) begin
            busy  <= 1'b1;
            state <= ARB_PICK;
          end
        end
        ARB_PICK: begin
          time_cnt <= 16'd0;
          if (pick_vld) begin
            grant_idx     <= pick_idx;
            send_btype    <= pick_bt;
            send_dlen     <= pick_dl;
            ram_addr_init <= pick_ad;
            fs_send       <= 1'b1;
            state         <= SEND_DATA;
          end else begin
            busy  <= 1'b0;
            state <= MAIN_WAIT;
          end
        end
        SEND_DATA: begin
          time_cnt <= time_cnt + 16'd1;
          if (fd_send) begin
            fs_send <= 1'b0;
            state   <= SEND_DONE;
          end else if (time_cnt >= TIMEOUT - 16'd1) begin
            fs_send     <= 1'b0;
            timeout_err <= 1'b1;
            state       <= SEND_ERR;
          end
        end
        SEND_DONE: begin
          time_cnt <= 16'd0;
          if (!fd_send) begin
            src_fd <= gnt_mask;
            state  <= SRC_DONE;
          end
        end
        SEND_ERR: begin
          time_cnt    <= 16'd0;
          timeout_err <= 1'b0;
          src_fd      <= gnt_mask;
          state       <= SRC_DONE;
        end
        SRC_DONE: begin
          time_cnt <= 16'd0;
          if (!fs_gnt) begin
            src_fd   <= '0;
            last_idx <= grant_idx;
            busy     <= 1'b0;
            state    <= MAIN_WAIT;
          end
        end
        default: begin
          state       <= MAIN_IDLE;
          time_cnt    <= 16'd0;
          fs_send     <= 1'b0;
          src_fd      <= '0;
          busy        <= 1'b0;
          timeout_err <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_com_arb.sv
// Self-checking bench for com_arb: vector table, corner
// sequences and randomized traffic against a round-robin model.
module tb_com_arb;
  import com_pkg::*;

  localparam int NS  = 3;
  localparam int TMO = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NS-1:0]     src_fs = '0;
  logic [NS-1:0]     src_fd;
  logic [4*NS-1:0]   src_btype;
  logic [12*NS-1:0]  src_dlen;
  logic [12*NS-1:0]  src_addr;
  logic              fs_send;
  logic              fd_send = 1'b0;
  logic [3:0]        send_btype;
  logic [11:0]       send_dlen;
  logic [11:0]       ram_addr_init;
  logic [1:0]        grant_idx;
  logic              busy;
  logic              timeout_err;

  com_arb #(.NUM_SRC(NS), .TIMEOUT(16'h0010)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .src_fs        (src_fs),
    .src_fd        (src_fd),
    .src_btype     (src_btype),
    .src_dlen      (src_dlen),
    .src_addr      (src_addr),
    .fs_send       (fs_send),
    .fd_send       (fd_send),
    .send_btype    (send_btype),
    .send_dlen     (send_dlen),
    .ram_addr_init (ram_addr_init),
    .grant_idx     (grant_idx),
    .busy          (busy),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0]  f_bt [NS];
  logic [11:0] f_dl [NS];
  logic [11:0] f_ad [NS];
  logic [1:0]  last_g;
  logic [NS-1:0] pend;

  typedef struct {
    logic [NS-1:0] req;
    int            delay;
    logic [1:0]    grant;
    bit            tmo;
  } vec_t;

  vec_t tbl [7];
  logic [1:0] rr_exp [4];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive_fields();
    for (int i = 0; i < NS; i++) begin
      src_btype[4*i +: 4] = f_bt[i];
      src_dlen[12*i +: 12] = f_dl[i];
      src_addr[12*i +: 12] = f_ad[i];
    end
  endtask

  // Next grant: first pending requester after the last winner.
  function automatic logic [1:0] model_pick();
    logic [1:0] j;
    for (int k = 1; k <= NS; k++) begin
      j = 2'((int'(last_g) + k) % NS);
      if (pend[j]) return j;
    end
    return 2'd0;
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_fs_send"}, fs_send, 0);
    check({tag, "_src_fd"}, src_fd, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_timeout_err"}, timeout_err, 0);
    check({tag, "_grant_idx"}, grant_idx, 0);
    check({tag, "_send_btype"}, send_btype, 0);
    check({tag, "_send_dlen"}, send_dlen, 0);
    check({tag, "_ram_addr"}, ram_addr_init, 0);
  endtask

  // One complete grant: fd_send returned `delay` cycles into
  // fs_send (never, if past the timeout window).
  task automatic serve(input int delay, input logic [1:0] g,
                       input bit tmo, input bit early);
    int lat, hi, pls, wt;
    logic [NS-1:0] oh;
    oh  = NS'(1) << g;
    lat = 0;
    pls = 0;
    while (!fs_send && lat < 10) begin
      @(negedge clk);
      lat++;
      if (timeout_err) pls++;
    end
    check("fs_latency", lat, 2);
    check("grant_idx", grant_idx, g);
    check("busy_send", busy, 1);
    check("send_btype", send_btype, f_bt[g]);
    check("send_dlen", send_dlen, f_dl[g]);
    check("ram_addr_init", ram_addr_init, f_ad[g]);
    hi = 0;
    while (fs_send && hi < 40) begin
      hi++;
      if (hi == 1) begin
        src_btype = ~src_btype;
        src_dlen  = ~src_dlen;
        src_addr  = ~src_addr;
        if (early) src_fs[g] = 1'b0;
      end
      if (hi == delay) fd_send = 1'b1;
      @(negedge clk);
      if (timeout_err) pls++;
    end
    check("fs_cycles", hi, tmo ? TMO : delay);
    check("hold_btype", send_btype, f_bt[g]);
    check("hold_dlen", send_dlen, f_dl[g]);
    check("hold_addr", ram_addr_init, f_ad[g]);
    drive_fields();
    if (!tmo) begin
      check("fd_before_fall", src_fd, 0);
      @(negedge clk);
      check("fd_before_fall2", src_fd, 0);
      fd_send = 1'b0;
    end
    wt = 0;
    while (src_fd == '0 && wt < 10) begin
      @(negedge clk);
      wt++;
      if (timeout_err) pls++;
    end
    check("src_fd", src_fd, oh);
    check("busy_done", busy, 1);
    check("timeout_pulses", pls, 32'(tmo));
    src_fs[g] = 1'b0;
    @(negedge clk);
    check("fd_release", src_fd, 0);
    check("busy_idle", busy, 0);
    last_g = g;
    pend   = pend & ~oh;
  endtask

  initial begin
    logic [NS-1:0] nw;
    logic [1:0] g;
    int d, w;

    f_bt[0] = 4'b1101; f_dl[0] = 12'h040; f_ad[0] = 12'h100;
    f_bt[1] = 4'h3;    f_dl[1] = 12'h7A5; f_ad[1] = 12'h2C0;
    f_bt[2] = 4'h9;    f_dl[2] = 12'hABC; f_ad[2] = 12'hF0F;
    drive_fields();
    last_g = 2'(NS - 1);
    pend   = '0;

    tbl[0] = '{3'b001, 3,  2'd0, 1'b0};
    tbl[1] = '{3'b100, 1,  2'd2, 1'b0};
    tbl[2] = '{3'b010, 20, 2'd1, 1'b1};
    tbl[3] = '{3'b110, 5,  2'd2, 1'b0};
    tbl[4] = '{3'b000, 16, 2'd1, 1'b0};
    tbl[5] = '{3'b011, 2,  2'd0, 1'b0};
    tbl[6] = '{3'b000, 17, 2'd1, 1'b1};
    rr_exp[0] = 2'd0; rr_exp[1] = 2'd1;
    rr_exp[2] = 2'd2; rr_exp[3] = 2'd0;

    #12;
    check_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      pend   = pend | tbl[i].req;
      src_fs = src_fs | tbl[i].req;
      serve(tbl[i].delay, tbl[i].grant, tbl[i].tmo, 1'b0);
    end

    // Reset in the middle of SEND_DATA.
    src_fs = 3'b100;
    w = 0;
    while (!fs_send && w < 10) begin
      @(negedge clk);
      w++;
    end
    check("pre_rst_fs", fs_send, 1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset_vals("mid_rst");
    src_fs = '0;
    @(negedge clk);
    rst_n = 1'b1;
    last_g = 2'(NS - 1);
    pend   = '0;
    repeat (3) @(negedge clk);
    check("post_rst_src_fd", src_fd, 0);

    // All three held, winner re-requests right after release.
    src_fs = 3'b111;
    pend   = 3'b111;
    for (int s = 0; s < 4; s++) begin
      serve(2, rr_exp[s], 1'b0, 1'b0);
      if (s < 3) begin
        src_fs[rr_exp[s]] = 1'b1;
        pend[rr_exp[s]]   = 1'b1;
      end
    end

    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < NS; i++) begin
        f_bt[i] = 4'($urandom);
        f_dl[i] = 12'($urandom);
        f_ad[i] = 12'($urandom);
      end
      drive_fields();
      nw = NS'($urandom);
      if ((pend | nw) == '0) nw = NS'(1) << $urandom_range(0, NS - 1);
      pend   = pend | nw;
      src_fs = src_fs | nw;
      g = model_pick();
      d = int'($urandom_range(1, 20));
      serve(d, g, d > TMO, $urandom_range(0, 3) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
